// File: rtl/ir_sirc_rx.sv
// ir_sirc_rx: SIRC-style IR frame receiver with synchroniser/deglitch, variable frame length,
// a one-entry valid/ready output buffer with overrun, error pulses and repeat-frame tagging.
module ir_sirc_rx #(
    parameter int BASE_PULSE_WIDTH = 30000,
    parameter int ERROR_PCT        = 10,
    parameter int MIN_BITS         = 12,
    parameter int MAX_BITS         = 20,
    parameter int GLITCH_CYCLES    = 16,
    parameter int REPEAT_WINDOW    = 3000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ir,
    output logic [MAX_BITS-1:0] data,
    output logic [4:0]          data_len,
    output logic                data_rpt,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                frame_err,
    output logic                overrun
);
    localparam int TMIN = BASE_PULSE_WIDTH * (100 - ERROR_PCT) / 100;
    localparam int TMAX = BASE_PULSE_WIDTH * (100 + ERROR_PCT) / 100;
    localparam int CMAX = 4 * TMAX + 1;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int GW   = $clog2(GLITCH_CYCLES + 1);
    localparam int RW   = $clog2(REPEAT_WINDOW + 1);
    localparam logic [CW-1:0] T1L  = CW'(TMIN);
    localparam logic [CW-1:0] T1H  = CW'(TMAX);
    localparam logic [CW-1:0] T2L  = CW'(2 * TMIN);
    localparam logic [CW-1:0] T2H  = CW'(2 * TMAX);
    localparam logic [CW-1:0] T4L  = CW'(4 * TMIN);
    localparam logic [CW-1:0] T4H  = CW'(4 * TMAX);
    localparam logic [CW-1:0] CSAT = CW'(CMAX);
    localparam logic [GW-1:0] GMAX = GW'(GLITCH_CYCLES - 1);
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_WINDOW);

    typedef enum logic [2:0] {IDLE, START, PAUSE, BIT, DRAIN} state_t;

    state_t              state;
    logic [1:0]          sync;
    logic                f;
    logic [GW-1:0]       gc;
    logic [CW-1:0]       cnt;
    logic [4:0]          nbits;
    logic [MAX_BITS-1:0] sh;
    logic [RW-1:0]       gap;
    logic                have_prev;
    logic [MAX_BITS-1:0] last_data;
    logic [4:0]          last_len;

    logic [CW-1:0] cnt_inc;
    logic          in1, in2, in4, nb_ok, rpt_n, commit;

    assign cnt_inc = (cnt == CSAT) ? cnt : cnt + CW'(1);
    assign in1     = cnt >= T1L && cnt <= T1H;
    assign in2     = cnt >= T2L && cnt <= T2H;
    assign in4     = cnt >= T4L && cnt <= T4H;
    assign nb_ok   = nbits >= 5'(MIN_BITS) && nbits <= 5'(MAX_BITS);
    assign rpt_n   = have_prev && gap < RMAX && sh == last_data && nbits == last_len;
    assign commit  = state == PAUSE && f && cnt > T2H && nb_ok;

    // A level change is accepted only after GLITCH_CYCLES identical samples, delaying both edges equally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            f    <= 1'b1;
            gc   <= '0;
        end else begin
            sync <= {sync[0], ir};
            if (sync[1] == f) begin
                gc <= '0;
            end else if (gc == GMAX) begin
                f  <= sync[1];
                gc <= '0;
            end else begin
                gc <= gc + GW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            nbits      <= '0;
            sh         <= '0;
            gap        <= '0;
            have_prev  <= 1'b0;
            last_data  <= '0;
            last_len   <= '0;
            data       <= '0;
            data_len   <= '0;
            data_rpt   <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            gap       <= commit ? '0 : (gap == RMAX ? gap : gap + RW'(1));
            // Every good frame updates the repeat reference, even one dropped by a full buffer.
            if (commit) begin
                have_prev <= 1'b1;
                last_data <= sh;
                last_len  <= nbits;
                if (!data_valid || data_ready) begin
                    data       <= sh;
                    data_len   <= nbits;
                    data_rpt   <= rpt_n;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
            case (state)
                IDLE: if (!f) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (f) begin
                    if (in4) begin
                        state <= PAUSE;
                        cnt   <= '0;
                        nbits <= '0;
                        sh    <= '0;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end else if (cnt > T4H) begin
                    frame_err <= 1'b1;
                    state     <= DRAIN;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
                PAUSE: if (f) begin
                    if (cnt > T2H) begin
                        frame_err <= !nb_ok;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else if (in1) begin
                    state <= BIT;
                    cnt   <= '0;
                end else begin
                    frame_err <= 1'b1;
                    state     <= DRAIN;
                    cnt       <= '0;
                end
                // A malformed bit drains the rest of the frame so its tail is not parsed as a new start.
                BIT: if (f) begin
                    if ((in1 || in2) && nbits < 5'(MAX_BITS)) begin
                        sh    <= {sh[MAX_BITS-2:0], in2};
                        nbits <= nbits + 5'd1;
                        state <= PAUSE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= DRAIN;
                    end
                    cnt <= '0;
                end else if (cnt > T2H) begin
                    frame_err <= 1'b1;
                    state     <= DRAIN;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
                DRAIN: if (!f) begin
                    cnt <= '0;
                end else if (cnt > T2H) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt_inc;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
